// File: rtl/game_pkg.sv
// Shared game-state types and constants for the lives tracker and lives display.
package game_pkg;

    typedef enum logic [0:0] {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    localparam int LIVES_W = 2;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/hit_channel.sv
// One player's hit path: rising-edge detect on the hit level plus the
// invulnerability cooldown down-counter that gates counted hits.
module hit_channel #(
    parameter int COOLDOWN = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic hit_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic counted_o
);

    localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic             hist_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clear_i (new game) discards a coincident edge; history still tracks the input
    assign counted_o = hit_i & ~hist_q & enable_i & ~clear_i & (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (counted_o) begin
            cnt_d = CNT_W'(COOLDOWN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hit_i;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/lives_tracker.sv
// Owns both players' life counters, the PLAY/OVER game FSM and the winner code
// driven to the lives display and end-of-game logic.
module lives_tracker
    import game_pkg::*;
#(
    parameter int START_LIVES = 3,
    parameter int COOLDOWN    = 25_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hit1,
    input  logic               hit2,
    input  logic               new_game,
    output logic [LIVES_W-1:0] lives1,
    output logic [LIVES_W-1:0] lives2,
    output logic               hit_taken1,
    output logic               hit_taken2,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives1_q, lives1_d;
    logic [LIVES_W-1:0] lives2_q, lives2_d;
    logic               ht1_q, ht1_d;
    logic               ht2_q, ht2_d;
    logic [1:0]         win_q, win_d;
    logic               counted1, counted2;
    logic               in_play;
    logic               dead1, dead2;

    assign in_play = (state_q == ST_PLAY);

    hit_channel #(.COOLDOWN(COOLDOWN)) u_ch1 (
        .clk       (clk),
        .rst       (rst),
        .hit_i     (hit1),
        .enable_i  (in_play),
        .clear_i   (new_game),
        .counted_o (counted1)
    );

    hit_channel #(.COOLDOWN(COOLDOWN)) u_ch2 (
        .clk       (clk),
        .rst       (rst),
        .hit_i     (hit2),
        .enable_i  (in_play),
        .clear_i   (new_game),
        .counted_o (counted2)
    );

    // counted hits only occur in PLAY, where lives are >= 1, so no underflow
    assign dead1 = counted1 && (lives1_q == LIVES_W'(1));
    assign dead2 = counted2 && (lives2_q == LIVES_W'(1));

    always_comb begin
        state_d  = state_q;
        lives1_d = lives1_q;
        lives2_d = lives2_q;
        win_d    = win_q;
        ht1_d    = 1'b0;
        ht2_d    = 1'b0;
        if (new_game) begin
            state_d  = ST_PLAY;
            lives1_d = LIVES_INIT;
            lives2_d = LIVES_INIT;
            win_d    = WIN_NONE;
        end else if (state_q == ST_PLAY) begin
            if (counted1) begin
                lives1_d = lives1_q - LIVES_W'(1);
                ht1_d    = 1'b1;
            end
            if (counted2) begin
                lives2_d = lives2_q - LIVES_W'(1);
                ht2_d    = 1'b1;
            end
            if (dead1 || dead2) begin
                state_d = ST_OVER;
                if (dead1 && dead2) begin
                    win_d = WIN_DRAW;
                end else if (dead1) begin
                    win_d = WIN_P2;
                end else begin
                    win_d = WIN_P1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_PLAY;
            lives1_q <= LIVES_INIT;
            lives2_q <= LIVES_INIT;
            ht1_q    <= 1'b0;
            ht2_q    <= 1'b0;
            win_q    <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            lives1_q <= lives1_d;
            lives2_q <= lives2_d;
            ht1_q    <= ht1_d;
            ht2_q    <= ht2_d;
            win_q    <= win_d;
        end
    end

    assign lives1     = lives1_q;
    assign lives2     = lives2_q;
    assign hit_taken1 = ht1_q;
    assign hit_taken2 = ht2_q;
    assign game_over  = (state_q == ST_OVER);
    assign winner     = win_q;

endmodule

// File: tb/tb_lives_tracker.sv
// Table-driven bench for lives_tracker (COOLDOWN=4, START_LIVES=3) with a
// queue scoreboard, plus a hand-written asynchronous reset sequence.
module tb_lives_tracker;

    logic       clk;
    logic       rst;
    logic       hit1;
    logic       hit2;
    logic       new_game;
    logic [1:0] lives1;
    logic [1:0] lives2;
    logic       hit_taken1;
    logic       hit_taken2;
    logic       game_over;
    logic [1:0] winner;

    lives_tracker #(.START_LIVES(3), .COOLDOWN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .hit1       (hit1),
        .hit2       (hit2),
        .new_game   (new_game),
        .lives1     (lives1),
        .lives2     (lives2),
        .hit_taken1 (hit_taken1),
        .hit_taken2 (hit_taken2),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       h1;
        logic       h2;
        logic       ng;
        logic [8:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [8:0] sb_q[$];
    int         checks = 0;
    int         passed = 0;

    function automatic logic [8:0] pack(input int l1, input int l2, input int t1,
                                        input int t2, input int go, input int win);
        return {2'(l1), 2'(l2), 1'(t1), 1'(t2), 1'(go), 2'(win)};
    endfunction

    task automatic add(input int n, input int h1, input int h2, input int ng,
                       input int l1, input int l2, input int t1, input int t2,
                       input int go, input int win);
        vec_t v;
        v.h1  = 1'(h1);
        v.h2  = 1'(h2);
        v.ng  = 1'(ng);
        v.exp = pack(l1, l2, t1, t2, go, win);
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    task automatic compare(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {lives1, lives2, hit_taken1, hit_taken2, game_over, winner};
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got l1=%0d l2=%0d ht1=%b ht2=%b go=%b win=%b, want l1=%0d l2=%0d ht1=%b ht2=%b go=%b win=%b",
                     name, act[8:7], act[6:5], act[4], act[3], act[2], act[1:0],
                     exp[8:7], exp[6:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic step(input logic h1, input logic h2, input logic ng,
                        input logic [8:0] exp, input string name);
        logic [8:0] e;
        @(negedge clk);
        hit1     = h1;
        hit2     = h2;
        new_game = ng;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compare(name, e);
    endtask

    initial begin
        //  n  h1 h2 ng  l1 l2 t1 t2 go win
        add(1, 0, 0, 0, 3, 3, 0, 0, 0, 0);   // idle after reset
        add(1, 1, 0, 0, 2, 3, 1, 0, 0, 0);   // hit1 held 10 cycles: one count
        add(9, 1, 0, 0, 2, 3, 0, 0, 0, 0);
        add(1, 0, 0, 0, 2, 3, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 3, 1, 0, 0, 0);   // edge N counted
        add(1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 3, 0, 0, 0, 0);   // N+2 dropped
        add(1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 3, 0, 0, 0, 0);   // N+4 dropped (last ignored edge)
        add(1, 0, 0, 1, 3, 3, 0, 0, 0, 0);   // restart in PLAY
        add(1, 0, 1, 0, 3, 2, 0, 1, 0, 0);   // p2 hit 1
        add(3, 0, 0, 0, 3, 2, 0, 0, 0, 0);
        add(1, 0, 1, 0, 3, 2, 0, 0, 0, 0);   // N+4 dropped
        add(1, 0, 0, 0, 3, 2, 0, 0, 0, 0);
        add(1, 0, 1, 0, 3, 1, 0, 1, 0, 0);   // p2 hit 2
        add(4, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 3, 0, 0, 1, 1, 1);   // N+5 counted: p2 out, p1 wins
        add(1, 1, 0, 0, 3, 0, 0, 0, 1, 1);   // hit in OVER ignored
        add(1, 0, 0, 0, 3, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1, 3, 3, 0, 0, 0, 0);   // new_game in OVER
        add(1, 1, 1, 0, 2, 2, 1, 1, 0, 0);   // simultaneous hits
        add(4, 0, 0, 0, 2, 2, 0, 0, 0, 0);
        add(1, 1, 1, 0, 1, 1, 1, 1, 0, 0);
        add(4, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1, 1, 1, 3);   // draw
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        add(1, 1, 0, 1, 3, 3, 0, 0, 0, 0);   // new_game beats hit in OVER
        add(1, 0, 0, 0, 3, 3, 0, 0, 0, 0);
        add(1, 1, 0, 1, 3, 3, 0, 0, 0, 0);   // new_game + hit1 in PLAY: discarded
        add(1, 1, 0, 0, 3, 3, 0, 0, 0, 0);   // still high: no new edge
        add(1, 0, 0, 0, 3, 3, 0, 0, 0, 0);
        add(1, 1, 0, 0, 2, 3, 1, 0, 0, 0);
        add(1, 0, 0, 1, 3, 3, 0, 0, 0, 0);   // new_game clears cooldown
        add(1, 1, 0, 0, 2, 3, 1, 0, 0, 0);   // counted on the next edge

        rst      = 1'b1;
        hit1     = 1'b0;
        hit2     = 1'b0;
        new_game = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", pack(3, 3, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].h1, tbl[i].h2, tbl[i].ng, tbl[i].exp, $sformatf("row%0d", i));
        end

        // asynchronous reset in the middle of a player 2 cooldown
        step(1'b0, 1'b1, 1'b0, pack(2, 2, 0, 1, 0, 0), "rst_pre_hit");
        step(1'b0, 1'b0, 1'b0, pack(2, 2, 0, 0, 0, 0), "rst_pre_cool");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare("rst_async", pack(3, 3, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, pack(3, 2, 0, 1, 0, 0), "rst_hit_after");
        step(1'b0, 1'b0, 1'b0, pack(3, 2, 0, 0, 0, 0), "rst_pulse_end");

        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lives_tracker.md
# lives_tracker

Game-state block that owns both players' life counters and drives the `lives1`/`lives2` buses consumed by the seven-segment lives display. It sits between the combat logic, which raises per-player hit signals, and the display and end-of-game logic. It covers:
- edge-detecting each hit,
- enforcing a per-player invulnerability cooldown,
- decrementing lives,
- declaring game over and the winner.

## Interface
Parameters:
- `START_LIVES`, default 3: lives loaded at reset and new game. Legal range 1–3.
- `COOLDOWN`, default 25_000_000: cycles a player ignores further hits after a counted hit. 0 disables the cooldown.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst`, input, 1: asynchronous, active-high reset.
- `hit1`, input, 1: player 1 was struck. Level from combat logic; only rising edges count.
- `hit2`, input, 1: player 2 was struck. Same rules as `hit1`.
- `new_game`, input, 1: synchronous restart request. Level; sampled every cycle.
- `lives1`, output, 2: player 1 lives remaining. Registered.
- `lives2`, output, 2: player 2 lives remaining. Registered.
- `hit_taken1`, output, 1: one-cycle pulse when a player 1 hit is counted.
- `hit_taken2`, output, 1: one-cycle pulse when a player 2 hit is counted.
- `game_over`, output, 1: high while in state OVER.
- `winner`, output, 2: result code. 00 = none, 01 = player 1, 10 = player 2, 11 = draw. Valid while `game_over` is high, otherwise 00.

## Operation
- Reset values (asynchronous):
  - `lives1` = `lives2` = `START_LIVES`
  - `hit_taken*` = 0, `game_over` = 0, `winner` = 00
  - cooldown counters = 0, hit history registers = 0
  - state = PLAY
- Edge detect: each hit input has a history register. A rising edge is `hitN` = 1 with history = 0 at a clock edge.
- Counted hit: requires all three of:
  - a rising edge,
  - state PLAY,
  - that player's cooldown counter = 0.
- Effect of a counted hit:
  - that player's lives decrement by 1,
  - its `hit_taken` pulses,
  - its cooldown counter loads `COOLDOWN`.
- Cooldown counters decrement by 1 per cycle while nonzero. Edges that arrive during cooldown are dropped, never queued.
- Holding a hit input high counts once. It must fall and rise again to count again.
- FSM states:
  - PLAY → OVER when any counted hit makes a player's lives 0.
  - OVER → PLAY on `new_game`.
  - PLAY → PLAY on `new_game`: restart.
- Winner on entering OVER:
  - only player 1 reaches 0: `winner` = 10,
  - only player 2 reaches 0: `winner` = 01,
  - both reach 0 in the same cycle: `winner` = 11.
- In OVER:
  - hits are ignored and produce no `hit_taken` pulses,
  - lives hold their values,
  - cooldown counters keep counting down.
- `new_game` in any state:
  - lives reload to `START_LIVES`,
  - cooldown counters clear,
  - `winner` = 00, `game_over` = 0.
- Priority: `new_game` beats any hit in the same cycle, and that hit is discarded. Hit history registers still update.
- Simultaneous hits on both players are independent. Both count if both are eligible.
- Lives never underflow: a player at 0 exists only in OVER, where hits are ignored.
- Arithmetic: lives are 2-bit unsigned. Cooldown counter width is `$clog2(COOLDOWN+1)`, minimum 1.

## Timing
- Hit latency: a rising edge sampled at clock edge N updates `lives`, `hit_taken`, `game_over` and `winner` at edge N. All are visible in the following cycle.
- `hit_taken` is high for exactly one cycle per counted hit.
- Cooldown window: after a counted hit at edge N, edges at N+1 through N+`COOLDOWN` are ignored. The earliest next counted hit is at edge N+`COOLDOWN`+1.
- `new_game` takes effect at the edge where it is sampled. Hits can be counted from the next edge.
- Reset asserted mid-game: all outputs take their reset values immediately, without waiting for a clock edge.
- No combinational path from any input to any output.

## Structure
- Shared package `game_pkg` holds:
  - the state enum (PLAY, OVER),
  - `LIVES_W` = 2,
  - winner codes `WIN_NONE`, `WIN_P1`, `WIN_P2`, `WIN_DRAW`.
  
  The display block uses the same `LIVES_W`.
- Sub-module `hit_channel`, instantiated once per player, contains:
  - hit history register and rising-edge detect,
  - cooldown counter,
  - `enable` (state is PLAY) and `clear` (`new_game`) inputs,
  - `counted` output.
- `lives_tracker` itself holds the lives registers, the FSM and the winner logic.

## Test plan
All scenarios run with `COOLDOWN` = 4 and `START_LIVES` = 3.
- Reset, then release: `lives1` = `lives2` = 3, `game_over` = 0, `winner` = 00, no `hit_taken` pulses.
- `hit1` held high for 10 cycles: `lives1` = 2, exactly one `hit_taken1` pulse, `lives2` stays 3.
- `hit1` pulsed at edges N, N+2, N+4, N+5: only N and N+5 count, `lives1` goes 3 → 2 → 1.
- Three spaced hits on player 2: `lives2` = 0, `game_over` = 1, `winner` = 01 at the third hit's edge. A further `hit1` leaves `lives1` unchanged.
- Both players at 1 life, `hit1` and `hit2` rise in the same cycle: both lives go to 0, `winner` = 11.
- `new_game` in OVER, and separately `new_game` together with `hit1` in PLAY: lives = 3, `game_over` = 0, no `hit_taken1`.
- `rst` asserted mid-cooldown: all outputs reset immediately, and a `hit2` edge right after `rst` is released is counted.
